// File: rtl/memio_mapped_ctrl.sv
// memio_mapped_ctrl
//   Memory-mapped I/O controller between the CPU data port and the memories and
//   peripherals. It decodes cpu_addr[31:28] into the following regions:
//     0x1  data memory (dmem), WORDSIZE wide, synchronous read
//     0x2  screen memory (smem), NCHAR_BITS wide, dual port (CPU and VGA read)
//     0x3  I/O: KEYDATA, KEYSTAT, ACCEL, CTRL, and OUTk output registers
//   Every read has one cycle of latency. Its result is qualified by cpu_rvalid,
//   and cpu_readdata holds its value between reads.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   cpu_wr, cpu_rd               one-cycle write / read strobes
//   cpu_addr, cpu_writedata      byte address (word aligned), write data
//   cpu_readdata, cpu_rvalid     read data and its strobe (cycle after cpu_rd)
//   out_regs                     N_OUT_REGS output registers, packed flat
//   accel_val                    accelerometer value, sampled on ACCEL read
//   keyb_valid, keyb_char        keyboard key strobe and code
//   vga_addr, vga_readdata       screen read port, one-cycle latency
//   irq                          keyboard interrupt (irq_en & FIFO not empty)
module memio_mapped_ctrl #(
  parameter int    WORDSIZE       = 32,
  parameter int    DMEM_WORDS     = 1024,
  parameter string DMEM_INIT      = "noname.mem",
  parameter int    SMEM_WORDS     = 1200,
  parameter string SMEM_INIT      = "noname.mem",
  parameter int    NCHAR_BITS     = 4,
  parameter int    N_OUT_REGS     = 4,
  parameter int    KEY_FIFO_DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             cpu_wr,
  input  logic                             cpu_rd,
  input  logic [31:0]                      cpu_addr,
  input  logic [WORDSIZE-1:0]              cpu_writedata,
  output logic [WORDSIZE-1:0]              cpu_readdata,
  output logic                             cpu_rvalid,
  output logic [N_OUT_REGS*WORDSIZE-1:0]   out_regs,
  input  logic [31:0]                      accel_val,
  input  logic                             keyb_valid,
  input  logic [7:0]                       keyb_char,
  input  logic [$clog2(SMEM_WORDS)-1:0]    vga_addr,
  output logic [NCHAR_BITS-1:0]            vga_readdata,
  output logic                             irq
);

  localparam int DA_W = $clog2(DMEM_WORDS);
  localparam int SA_W = $clog2(SMEM_WORDS);
  localparam int KP_W = $clog2(KEY_FIFO_DEPTH);
  localparam int KC_W = KP_W + 1;

  typedef enum logic [1:0] {SEL_IO, SEL_DMEM, SEL_SMEM} rsel_t;

  // Contents come from the init file through the synthesis tool's RAM init attribute.
  (* ram_init_file = DMEM_INIT *) logic [WORDSIZE-1:0]   dmem [DMEM_WORDS];
  (* ram_init_file = SMEM_INIT *) logic [NCHAR_BITS-1:0] smem [SMEM_WORDS];
  logic [7:0] keyq [KEY_FIFO_DEPTH];

  logic [KP_W-1:0] wptr, rptr;
  logic [KC_W-1:0] count;
  logic            ovf;
  logic            irq_en;

  // Decode and I/O read-data selection. All of this is computed from the state
  // before the current edge.
  logic [3:0]          region;
  logic [DA_W-1:0]     dmem_idx;
  logic [SA_W-1:0]     smem_idx;
  logic [5:0]          io_off;
  logic                is_dmem, is_smem, is_io;
  logic                fifo_empty, fifo_full;
  logic                pop, push_ok, ovf_set, ovf_clr;
  logic [WORDSIZE-1:0] io_rdata;

  assign region   = cpu_addr[31:28];
  assign dmem_idx = cpu_addr[2 +: DA_W];
  assign smem_idx = cpu_addr[2 +: SA_W];
  assign io_off   = cpu_addr[7:2];
  assign is_dmem  = (region == 4'h1) && (int'(dmem_idx) < DMEM_WORDS);
  assign is_smem  = (region == 4'h2) && (int'(smem_idx) < SMEM_WORDS);
  assign is_io    = (region == 4'h3);

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == KC_W'(KEY_FIFO_DEPTH));
  assign pop        = cpu_rd && is_io && (io_off == 6'd0) && !fifo_empty;
  // When the FIFO is full, a pop in the same cycle frees the slot the push needs.
  assign push_ok    = keyb_valid && (!fifo_full || pop);
  assign ovf_set    = keyb_valid && !push_ok;
  assign ovf_clr    = cpu_wr && is_io && (io_off == 6'd1) && cpu_writedata[1];

  always_comb begin
    io_rdata = '0;
    case (io_off)
      6'd0: if (!fifo_empty) io_rdata = WORDSIZE'(keyq[rptr]);
      6'd1: begin
        io_rdata[8 +: KC_W] = count;
        io_rdata[1]         = ovf;
        io_rdata[0]         = fifo_empty;
      end
      6'd2: io_rdata = WORDSIZE'(accel_val);
      6'd3: io_rdata[0] = irq_en;
      default: begin
        for (int k = 0; k < N_OUT_REGS; k++)
          if (io_off == 6'(16 + k)) io_rdata = out_regs[k*WORDSIZE +: WORDSIZE];
      end
    endcase
  end

  // Stage p1: captured read results, valid strobe and control state
  rsel_t               sel_p1;
  logic [WORDSIZE-1:0] io_q_p1;
  logic [WORDSIZE-1:0] dmem_q_p1;
  logic [NCHAR_BITS-1:0] smem_q_p1;
  logic                vld_p1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1   <= 1'b0;
      sel_p1   <= SEL_IO;
      io_q_p1  <= '0;
      out_regs <= '0;
      irq_en   <= 1'b0;
      irq      <= 1'b0;
      ovf      <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
    end else begin
      vld_p1 <= cpu_rd;
      if (cpu_rd) begin
        // Unmapped regions are steered to the I/O path with zero data.
        sel_p1  <= is_dmem ? SEL_DMEM : (is_smem ? SEL_SMEM : SEL_IO);
        io_q_p1 <= is_io ? io_rdata : '0;
      end
      if (cpu_wr && is_io) begin
        if (io_off == 6'd3) irq_en <= cpu_writedata[0];
        for (int k = 0; k < N_OUT_REGS; k++)
          if (io_off == 6'(16 + k)) out_regs[k*WORDSIZE +: WORDSIZE] <= cpu_writedata;
      end
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      count <= count + KC_W'(push_ok) - KC_W'(pop);
      // A clear and an overflow in the same cycle leave the flag set.
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      irq <= irq_en && !fifo_empty;
    end
  end

  // Memory arrays: read-before-write, so a same-address read sees the old word
  always_ff @(posedge clk) begin
    if (cpu_rd && is_dmem) dmem_q_p1 <= dmem[dmem_idx];
    if (cpu_wr && is_dmem) dmem[dmem_idx] <= cpu_writedata;
    if (cpu_rd && is_smem) smem_q_p1 <= smem[smem_idx];
    if (cpu_wr && is_smem) smem[smem_idx] <= cpu_writedata[NCHAR_BITS-1:0];
    vga_readdata <= smem[vga_addr];
    if (push_ok) keyq[wptr] <= keyb_char;
  end

  always_comb begin
    case (sel_p1)
      SEL_DMEM: cpu_readdata = dmem_q_p1;
      SEL_SMEM: cpu_readdata = WORDSIZE'(smem_q_p1);
      default:  cpu_readdata = io_q_p1;
    endcase
  end

  assign cpu_rvalid = vld_p1;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[27:8], cpu_addr[1:0]};

endmodule

// File: tb/tb_memio_mapped_ctrl.sv
module tb_memio_mapped_ctrl;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         cpu_wr = 1'b0;
  logic         cpu_rd = 1'b0;
  logic [31:0]  cpu_addr = '0;
  logic [31:0]  cpu_writedata = '0;
  logic [31:0]  cpu_readdata;
  logic         cpu_rvalid;
  logic [127:0] out_regs;
  logic [31:0]  accel_val = '0;
  logic         keyb_valid = 1'b0;
  logic [7:0]   keyb_char = '0;
  logic [10:0]  vga_addr = '0;
  logic [3:0]   vga_readdata;
  logic         irq;

  int n_vec = 0;
  int n_err = 0;

  memio_mapped_ctrl dut (
    .clk(clk), .reset_n(reset_n), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
    .cpu_addr(cpu_addr), .cpu_writedata(cpu_writedata),
    .cpu_readdata(cpu_readdata), .cpu_rvalid(cpu_rvalid), .out_regs(out_regs),
    .accel_val(accel_val), .keyb_valid(keyb_valid), .keyb_char(keyb_char),
    .vga_addr(vga_addr), .vga_readdata(vga_readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cpu_addr = a; cpu_writedata = d; cpu_wr = 1'b1;
    tick();
    cpu_wr = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    cpu_addr = a; cpu_rd = 1'b1;
    tick();
    cpu_rd = 1'b0;
    chk({tag, "_vld"}, 128'(cpu_rvalid), 128'(1'b1));
    chk(tag, 128'(cpu_readdata), 128'(exp));
  endtask

  task automatic push(input logic [7:0] c);
    keyb_char = c; keyb_valid = 1'b1;
    tick();
    keyb_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rvalid", 128'(cpu_rvalid), 128'(0));
    chk("rst_rdata", 128'(cpu_readdata), 128'(0));
    chk("rst_out", out_regs, 128'(0));
    chk("rst_irq", 128'(irq), 128'(0));
    reset_n = 1'b1;
    tick();

    // Output registers
    for (int k = 0; k < 4; k++) rd_chk("out_rst", 32'h3000_0040 + 32'(4*k), 32'h0);
    tick();
    chk("rvalid_drop", 128'(cpu_rvalid), 128'(0));
    chk("rdata_hold", 128'(cpu_readdata), 128'(0));
    wr(32'h3000_0040, 32'h0000_ABCD);
    chk("out0_vis", 128'(out_regs[15:0]), 128'(16'hABCD));
    rd_chk("out0_rb", 32'h3000_0040, 32'h0000_ABCD);
    wr(32'h3000_004C, 32'hDEAD_BEEF);
    chk("out3_vis", 128'(out_regs[127:96]), 128'(32'hDEAD_BEEF));

    // Memories and VGA port
    wr(32'h1000_0010, 32'h1234_5678);
    rd_chk("dmem_rb", 32'h1000_0010, 32'h1234_5678);
    wr(32'h2000_0008, 32'hFFFF_FFF5);
    rd_chk("smem_rb", 32'h2000_0008, 32'h0000_0005);
    vga_addr = 11'd2;
    tick();
    chk("vga_rd", 128'(vga_readdata), 128'(4'h5));

    // Read and write together: read returns the pre-write value
    wr(32'h3000_0044, 32'h0000_1111);
    cpu_addr = 32'h3000_0044; cpu_writedata = 32'h0000_2222; cpu_wr = 1'b1; cpu_rd = 1'b1;
    tick();
    cpu_wr = 1'b0; cpu_rd = 1'b0;
    chk("rw_old", 128'(cpu_readdata), 128'(32'h1111));
    rd_chk("rw_new", 32'h3000_0044, 32'h0000_2222);

    // Unmapped and read-only
    rd_chk("unmapped", 32'h5000_0000, 32'h0);
    accel_val = 32'hCAFE_F00D;
    wr(32'h3000_0008, 32'h0);
    rd_chk("accel", 32'h3000_0008, 32'hCAFE_F00D);

    // Keyboard FIFO fill, overflow, drain
    for (int i = 0; i < 8; i++) push(8'h41 + 8'(i));
    rd_chk("kstat_full", 32'h3000_0004, 32'h0000_0800);
    push(8'h49);
    rd_chk("kstat_ovf", 32'h3000_0004, 32'h0000_0802);
    for (int i = 0; i < 8; i++) rd_chk("kdata", 32'h3000_0000, 32'h41 + 32'(i));
    rd_chk("kdata_empty", 32'h3000_0000, 32'h0);
    rd_chk("kstat_empty", 32'h3000_0004, 32'h0000_0003);
    wr(32'h3000_0004, 32'h2);
    rd_chk("kstat_clr", 32'h3000_0004, 32'h0000_0001);

    // Full FIFO: push and pop in one cycle
    for (int i = 0; i < 8; i++) push(8'h41 + 8'(i));
    keyb_char = 8'h50; keyb_valid = 1'b1; cpu_addr = 32'h3000_0000; cpu_rd = 1'b1;
    tick();
    keyb_valid = 1'b0; cpu_rd = 1'b0;
    chk("full_pp_data", 128'(cpu_readdata), 128'(32'h41));
    rd_chk("full_pp_stat", 32'h3000_0004, 32'h0000_0800);
    for (int i = 0; i < 7; i++) rd_chk("full_pp_order", 32'h3000_0000, 32'h42 + 32'(i));
    rd_chk("full_pp_last", 32'h3000_0000, 32'h50);

    // Empty FIFO: push and pop in one cycle
    keyb_char = 8'h60; keyb_valid = 1'b1; cpu_addr = 32'h3000_0000; cpu_rd = 1'b1;
    tick();
    keyb_valid = 1'b0; cpu_rd = 1'b0;
    chk("empty_pp_data", 128'(cpu_readdata), 128'(0));
    rd_chk("empty_pp_stat", 32'h3000_0004, 32'h0000_0100);
    rd_chk("empty_pp_pop", 32'h3000_0000, 32'h60);

    // Interrupt
    wr(32'h3000_000C, 32'h1);
    tick();
    chk("irq_empty", 128'(irq), 128'(0));
    rd_chk("ctrl_rb", 32'h3000_000C, 32'h1);
    push(8'h33);
    chk("irq_lag", 128'(irq), 128'(0));
    tick();
    chk("irq_set", 128'(irq), 128'(1));
    rd_chk("irq_pop", 32'h3000_0000, 32'h33);
    tick();
    chk("irq_clr", 128'(irq), 128'(0));

    // Reset during a read
    cpu_addr = 32'h1000_0010; cpu_rd = 1'b1; reset_n = 1'b0;
    tick();
    chk("mid_rvalid", 128'(cpu_rvalid), 128'(0));
    chk("mid_rdata", 128'(cpu_readdata), 128'(0));
    chk("mid_out", out_regs, 128'(0));
    cpu_rd = 1'b0; reset_n = 1'b1;
    tick();
    chk("mid_no_vld", 128'(cpu_rvalid), 128'(0));
    rd_chk("mid_dmem", 32'h1000_0010, 32'h1234_5678);
    rd_chk("mid_ctrl", 32'h3000_000C, 32'h0);
    rd_chk("mid_kstat", 32'h3000_0004, 32'h0000_0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
